vec_elem_seq: RTL and testbench
===============================

Name: vec_elem_seq

Overview:
Element-group sequencer for the vector co-processor execution datapath. It accepts one decoded vector arithmetic instruction at a time, together with the vl and vstart values current at acceptance, and emits one beat per LANES-element group to the lane datapath. Each beat carries the base element index, per-lane enables and first/last flags. Configuration instructions (vsetvli/vsetivli/vsetvl) are resolved upstream by the CSR decode stage and never reach this block.

Parameters:
XLEN, 32, instruction/scalar width
VLEN, 512, vector register length in bits; max vl = VLEN (SEW=8, LMUL=8)
LANES, 4, elements processed per beat; power of two, 1..16
VLW, $clog2(VLEN)+1, width of vl/vstart/index fields (derived)

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
inst_valid_i  in  1  instruction offered
inst_ready_o  out  1  sequencer can accept; high only in IDLE
inst_i  in  XLEN  vector instruction word
vl_i  in  VLW  current vl; sampled on accept
vstart_i  in  VLW  current vstart; sampled on accept
flush_i  in  1  synchronous abort of current instruction
beat_valid_o  out  1  beat presented to datapath
beat_ready_i  in  1  datapath consumes beat
beat_inst_o  out  XLEN  latched instruction word
beat_idx_o  out  VLW  element index of lane 0 (multiple of LANES)
beat_lane_en_o  out  LANES  bit i enables element beat_idx_o+i
beat_first_o  out  1  first beat of instruction
beat_last_o  out  1  last beat of instruction
done_o  out  1  one-cycle completion pulse
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, n_rst=0): state IDLE; all outputs 0 except inst_ready_o=1; latched inst/vl/idx cleared. Takes effect immediately, mid-operation included; no done_o is produced for an aborted instruction.
- States: IDLE, RUN, DONE.
- IDLE: inst_ready_o=1. On inst_valid_i&&inst_ready_o, latch inst_i, vl_i, vstart_i. If vstart_i>=vl_i (including vl=0), go to DONE. Otherwise go to RUN with idx = vstart_i rounded down to a multiple of LANES.
- RUN: beat_valid_o=1. lane_en[i] = (idx+i >= vstart) && (idx+i < vl). beat_first_o=1 on the first beat only. beat_last_o=1 when idx+LANES >= vl.
  - On beat_valid_o&&beat_ready_i: if last, go to DONE; else idx += LANES.
  - While beat_ready_i=0, all beat_* outputs hold stable.
- DONE: done_o=1 for exactly one cycle, inst_ready_o=0; then IDLE.
- Latency: first beat is valid the cycle after accept. done_o is asserted the cycle after the last handshake, or the cycle after accept for an empty instruction. Minimum spacing between accepts is beats+2 cycles.
- flush_i has priority over all handshakes in every state. Next state is IDLE with beat_valid_o=0 and no done_o. A flush in IDLE is a no-op.
- Width rules: idx arithmetic uses VLW bits; idx+LANES is computed at VLW+1 bits so vl=VLEN cannot wrap.
- vl_i and vstart_i changes after accept are ignored.

Optional Feature:
VEC_SEQ_MASK_EN
- With the macro defined: adds input v0_i [VLEN-1:0]. When inst_i[25] (vm)=0, beat_lane_en_o[i] is additionally ANDed with v0_i[idx+i]. v0_i is sampled per beat. Beats with all lanes masked are still emitted, so beat count is unchanged. vm=1 ignores v0_i.
- Without it: no v0_i port; lane enables depend only on vstart and vl.

Test Plan:
1. LANES=4, vl=10, vstart=0, beat_ready_i=1 -> three beats: idx 0/4/8, lane_en 1111/1111/0011; first on beat 0, last on beat 2; done_o one cycle after beat 2; inst_ready_o high the following cycle.
2. vl=10, vstart=5 -> two beats: idx 4 lane_en 1110, idx 8 lane_en 0011; first on the idx-4 beat.
3. vl=0, and separately vstart=12 with vl=10 -> no beat_valid_o; done_o in the cycle after accept.
4. vl=16, beat_ready_i low for 3 cycles during beat idx 4 -> beat_* stable throughout; four beats total; done_o after idx 12.
5. flush_i during beat idx 4 of vl=16 -> beat_valid_o=0 next cycle, no done_o, inst_ready_o=1; a new instruction is accepted next.
6. n_rst low mid-RUN -> outputs at reset values immediately. vl=VLEN=512 run -> 128 beats, last idx 508, no wrap. With VEC_SEQ_MASK_EN, vm=0 and v0=...0101 -> beat 0 lane_en 0101.

Source files
------------

// File: rtl/vec_elem_seq.sv
// vec_elem_seq: per-instruction element-group beat sequencer; VEC_SEQ_MASK_EN adds v0_i lane masking
module vec_elem_seq #(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int LANES = 4,
    parameter int VLW   = $clog2(VLEN) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [XLEN-1:0]  inst_i,
    input  logic [VLW-1:0]   vl_i,
    input  logic [VLW-1:0]   vstart_i,
    input  logic             flush_i,
`ifdef VEC_SEQ_MASK_EN
    input  logic [VLEN-1:0]  v0_i,
`endif
    output logic             beat_valid_o,
    input  logic             beat_ready_i,
    output logic [XLEN-1:0]  beat_inst_o,
    output logic [VLW-1:0]   beat_idx_o,
    output logic [LANES-1:0] beat_lane_en_o,
    output logic             beat_first_o,
    output logic             beat_last_o,
    output logic             done_o,
    output logic             busy_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] inst_q;
    logic [VLW-1:0]  vl_q;
    logic [VLW-1:0]  vstart_q;
    logic [VLW-1:0]  idx_q;
    logic            first_q;
    logic            run;
    logic            last;

    assign run            = state == S_RUN;
    assign last           = ({1'b0, idx_q} + (VLW+1)'(LANES)) >= {1'b0, vl_q};
    assign inst_ready_o   = state == S_IDLE;
    assign busy_o         = state != S_IDLE;
    assign done_o         = state == S_DONE;
    assign beat_valid_o   = run;
    assign beat_first_o   = run && first_q;
    assign beat_last_o    = run && last;
    assign beat_inst_o    = inst_q;
    assign beat_idx_o     = idx_q;

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        logic [VLW-1:0] e;
        assign e = idx_q + VLW'(i);
`ifdef VEC_SEQ_MASK_EN
        assign beat_lane_en_o[i] = run && e >= vstart_q && e < vl_q &&
                                   (inst_q[25] || v0_i[e[$clog2(VLEN)-1:0]]);
`else
        assign beat_lane_en_o[i] = run && e >= vstart_q && e < vl_q;
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            inst_q   <= '0;
            vl_q     <= '0;
            vstart_q <= '0;
            idx_q    <= '0;
            first_q  <= 1'b0;
        end else if (flush_i) begin
            state <= S_IDLE;
        end else if (state == S_IDLE && inst_valid_i) begin
            inst_q   <= inst_i;
            vl_q     <= vl_i;
            vstart_q <= vstart_i;
            idx_q    <= vstart_i & ~VLW'(LANES - 1);
            first_q  <= 1'b1;
            state    <= (vstart_i >= vl_i) ? S_DONE : S_RUN;
        end else if (run && beat_ready_i) begin
            first_q <= 1'b0;
            idx_q   <= last ? idx_q : idx_q + VLW'(LANES);
            state   <= last ? S_DONE : S_RUN;
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_vec_elem_seq.sv
// tb_vec_elem_seq: directed checks of vec_elem_seq beats, stalls, flush, reset and full-length vl
module tb_vec_elem_seq;
    localparam int XLEN  = 32;
    localparam int VLEN  = 512;
    localparam int LANES = 4;
    localparam int VLW   = $clog2(VLEN) + 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             inst_valid_i;
    logic             inst_ready_o;
    logic [XLEN-1:0]  inst_i;
    logic [VLW-1:0]   vl_i;
    logic [VLW-1:0]   vstart_i;
    logic             flush_i;
    logic             beat_valid_o;
    logic             beat_ready_i;
    logic [XLEN-1:0]  beat_inst_o;
    logic [VLW-1:0]   beat_idx_o;
    logic [LANES-1:0] beat_lane_en_o;
    logic             beat_first_o;
    logic             beat_last_o;
    logic             done_o;
    logic             busy_o;
`ifdef VEC_SEQ_MASK_EN
    logic [VLEN-1:0]  v0_i;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    vec_elem_seq #(.XLEN(XLEN), .VLEN(VLEN), .LANES(LANES)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .inst_valid_i(inst_valid_i),
        .inst_ready_o(inst_ready_o),
        .inst_i(inst_i),
        .vl_i(vl_i),
        .vstart_i(vstart_i),
        .flush_i(flush_i),
`ifdef VEC_SEQ_MASK_EN
        .v0_i(v0_i),
`endif
        .beat_valid_o(beat_valid_o),
        .beat_ready_i(beat_ready_i),
        .beat_inst_o(beat_inst_o),
        .beat_idx_o(beat_idx_o),
        .beat_lane_en_o(beat_lane_en_o),
        .beat_first_o(beat_first_o),
        .beat_last_o(beat_last_o),
        .done_o(done_o),
        .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [3:0] en,
                            input logic first, input logic last);
        chk({tag, ".valid"}, 32'(beat_valid_o), 32'd1);
        chk({tag, ".idx"}, 32'(beat_idx_o), 32'(idx));
        chk({tag, ".en"}, 32'(beat_lane_en_o), 32'(en));
        chk({tag, ".first"}, 32'(beat_first_o), 32'(first));
        chk({tag, ".last"}, 32'(beat_last_o), 32'(last));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"}, 32'(done_o), 32'd1);
        chk({tag, ".bvalid"}, 32'(beat_valid_o), 32'd0);
        chk({tag, ".iready"}, 32'(inst_ready_o), 32'd0);
        @(negedge clk);
        chk({tag, ".idle_ready"}, 32'(inst_ready_o), 32'd1);
        chk({tag, ".idle_done"}, 32'(done_o), 32'd0);
    endtask

    task automatic accept(input logic [31:0] inst, input int vl, input int vstart);
        inst_valid_i = 1'b1;
        inst_i       = inst;
        vl_i         = VLW'(vl);
        vstart_i     = VLW'(vstart);
        @(negedge clk);
        inst_valid_i = 1'b0;
        vl_i         = VLW'(3);
        vstart_i     = VLW'(1);
    endtask

    initial begin
        n_rst        = 1'b0;
        inst_valid_i = 1'b0;
        inst_i       = '0;
        vl_i         = '0;
        vstart_i     = '0;
        flush_i      = 1'b0;
        beat_ready_i = 1'b1;
`ifdef VEC_SEQ_MASK_EN
        v0_i         = '0;
`endif
        #3;
        chk("rst.iready", 32'(inst_ready_o), 32'd1);
        chk("rst.bvalid", 32'(beat_valid_o), 32'd0);
        chk("rst.done", 32'(done_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        accept(32'h1234_5677, 10, 0);
        chk("t1.inst", beat_inst_o, 32'h1234_5677);
        chk("t1.busy", 32'(busy_o), 32'd1);
        chk_beat("t1.b0", 0, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("t1.b1", 4, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        chk_beat("t1.b2", 8, 4'b0011, 1'b0, 1'b1);
        @(negedge clk);
        chk_done("t1");

        accept(32'h0000_0011, 10, 5);
        chk_beat("t2.b0", 4, 4'b1110, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("t2.b1", 8, 4'b0011, 1'b0, 1'b1);
        @(negedge clk);
        chk_done("t2");

        accept(32'h0000_0022, 0, 0);
        chk_done("t3a");
        accept(32'h0000_0033, 10, 12);
        chk_done("t3b");

        accept(32'h0000_0044, 16, 0);
        chk_beat("t4.b0", 0, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("t4.b1", 4, 4'b1111, 1'b0, 1'b0);
        beat_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_beat("t4.hold", 4, 4'b1111, 1'b0, 1'b0);
            chk("t4.hold_inst", beat_inst_o, 32'h0000_0044);
        end
        beat_ready_i = 1'b1;
        @(negedge clk);
        chk_beat("t4.b2", 8, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        chk_beat("t4.b3", 12, 4'b1111, 1'b0, 1'b1);
        @(negedge clk);
        chk_done("t4");

        accept(32'h0000_0055, 16, 0);
        chk_beat("t5.b0", 0, 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("t5.b1", 4, 4'b1111, 1'b0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t5.bvalid", 32'(beat_valid_o), 32'd0);
        chk("t5.done", 32'(done_o), 32'd0);
        chk("t5.iready", 32'(inst_ready_o), 32'd1);
        accept(32'h0000_0066, 4, 0);
        chk("t5.inst", beat_inst_o, 32'h0000_0066);
        chk_beat("t5.n0", 0, 4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        chk_done("t5n");

        accept(32'h0000_0077, 16, 0);
        chk_beat("t6.b0", 0, 4'b1111, 1'b1, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        chk("t6.bvalid", 32'(beat_valid_o), 32'd0);
        chk("t6.iready", 32'(inst_ready_o), 32'd1);
        chk("t6.busy", 32'(busy_o), 32'd0);
        chk("t6.done", 32'(done_o), 32'd0);
        chk("t6.idx", 32'(beat_idx_o), 32'd0);
        chk("t6.en", 32'(beat_lane_en_o), 32'd0);
        chk("t6.inst", beat_inst_o, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk("t6.nodone", 32'(done_o), 32'd0);

        accept(32'h0000_0088, VLEN, 0);
        for (int b = 0; b < VLEN / LANES; b++) begin
            chk_beat("t7.beat", b * LANES, 4'b1111, b == 0, b == VLEN / LANES - 1);
            @(negedge clk);
        end
        chk_done("t7");

`ifdef VEC_SEQ_MASK_EN
        v0_i = VLEN'(5);
        accept(32'h0000_0000, 8, 0);
        chk_beat("t8.b0", 0, 4'b0101, 1'b1, 1'b0);
        @(negedge clk);
        chk_beat("t8.b1", 4, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        chk_done("t8");
        accept(32'h0200_0000, 4, 0);
        chk_beat("t8.vm1", 0, 4'b1111, 1'b1, 1'b1);
        @(negedge clk);
        chk_done("t8vm");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
